// File: rtl/switch_debounce_ctrl.sv
// Switch debouncer with edge capture and a 4-register Avalon-MM slave; SWITCH_DEBOUNCE_IRQ_EN adds EDGE/MASK/irq.
// Latency: 2 sync cycles + STABLE_TICKS ticks to commit, 1-cycle reads; no backpressure, slave always accepts.
module switch_debounce_ctrl #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STABLE_TICKS    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]    LAST_N   = 3'(STABLE_TICKS);

    typedef enum logic {ST_STABLE, ST_PEND} state_t;

    logic [WIDTH-1:0] meta_q, sync_q, stable_q, stable_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    state_t           st_q  [WIDTH];
    state_t           st_d  [WIDTH];
    logic [2:0]       cnt_q [WIDTH];
    logic [2:0]       cnt_d [WIDTH];
    logic             ctrl_q, ctrl_d;
    logic [31:0]      rd_d, readdata_q;

    wire unused_wd = &{1'b0, writedata};

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign ctrl_d = (write && address == 2'd3) ? writedata[0] : ctrl_q;

    // PEND(n) is represented as ST_PEND with cnt = n; cnt is 0 in ST_STABLE.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (ctrl_q) begin
                st_d[i]     = ST_STABLE;
                cnt_d[i]    = 3'd0;
                stable_d[i] = sync_q[i];
            end else if (tick) begin
                case (st_q[i])
                    ST_STABLE: begin
                        if (sync_q[i] != stable_q[i]) begin
                            if (STABLE_TICKS == 1) begin
                                stable_d[i] = sync_q[i];
                            end else begin
                                st_d[i]  = ST_PEND;
                                cnt_d[i] = 3'd1;
                            end
                        end
                    end
                    default: begin
                        if (sync_q[i] == stable_q[i]) begin
                            st_d[i]  = ST_STABLE;
                            cnt_d[i] = 3'd0;
                        end else if (cnt_q[i] + 3'd1 == LAST_N) begin
                            stable_d[i] = sync_q[i];
                            st_d[i]     = ST_STABLE;
                            cnt_d[i]    = 3'd0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 3'd1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            stable_q   <= '0;
            pre_q      <= '0;
            ctrl_q     <= 1'b0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                st_q[i]  <= ST_STABLE;
                cnt_q[i] <= 3'd0;
            end
        end else begin
            meta_q     <= in_port;
            sync_q     <= meta_q;
            stable_q   <= stable_d;
            pre_q      <= pre_d;
            ctrl_q     <= ctrl_d;
            readdata_q <= rd_d;
            for (int i = 0; i < WIDTH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d, edge_q, edge_d, w1c;
    logic             irq_q;

    assign mask_d = (write && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
    assign w1c    = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
    // A commit in the same cycle as a W1C wins, so the new change is never lost.
    assign edge_d = (edge_q & ~w1c) | (stable_q ^ stable_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= |(edge_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_d = '0;
        case (address)
            2'd0: rd_d[WIDTH-1:0] = stable_q;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
            2'd1: rd_d[WIDTH-1:0] = mask_q;
            2'd2: rd_d[WIDTH-1:0] = edge_q;
`endif
            2'd3: rd_d[0] = ctrl_q;
            default: rd_d = '0;
        endcase
    end

    assign readdata = readdata_q;
endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Directed bench for switch_debounce_ctrl with DEBOUNCE_CYCLES=4, STABLE_TICKS=3.
module tb_switch_debounce_ctrl;
    localparam int WIDTH = 10;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       address = 2'd0;
    logic             write = 1'b0;
    logic [31:0]      writedata = 32'd0;
    logic [WIDTH-1:0] in_port = '0;
    logic [31:0]      readdata;
    logic             irq;

    int nchk = 0;
    int nerr = 0;
    int cyc_n = 0;

    switch_debounce_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .STABLE_TICKS(3)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_to(input int n);
        while (cyc_n < n) cyc();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        write = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc_n = 0;
    endtask

    function automatic logic [31:0] ie(input logic [31:0] v);
        return IRQ_EN ? v : 32'd0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{2'd0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{2'd1, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{2'd2, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{2'd0, 1'b1, 32'h3FF,      32'h0};
        vecs[5]  = '{2'd1, 1'b1, 32'hFFFFFFFF, ie(32'h3FF)};
        vecs[6]  = '{2'd3, 1'b1, 32'hFFFFFFFE, 32'h0};
        vecs[7]  = '{2'd3, 1'b1, 32'h1,        32'h1};
        vecs[8]  = '{2'd3, 1'b1, 32'h0,        32'h0};
        vecs[9]  = '{2'd1, 1'b1, 32'h155,      ie(32'h155)};
        vecs[10] = '{2'd2, 1'b1, 32'h3FF,      32'h0};
        vecs[11] = '{2'd1, 1'b1, 32'h0,        32'h0};

        // Register access table
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            address   = vecs[i].addr;
            write     = vecs[i].wr;
            writedata = vecs[i].wdata;
            cyc();
            write = 1'b0;
            cyc();
            check($sformatf("reg vec%0d readdata", i), readdata, vecs[i].exp_rd);
            check($sformatf("reg vec%0d irq", i), {31'd0, irq}, 32'd0);
        end

        // Debounced commit, irq latency, W1C, and W1C colliding with a commit
        reset_dut();
        in_port = 10'h001; address = 2'd1; write = 1'b1; writedata = 32'h1;
        run_to(1);
        write = 1'b0; address = 2'd0;
        run_to(11); check("data before commit", readdata, 32'h0);
        run_to(12); check("data at commit edge", readdata, 32'h0);
                    check("irq at commit edge", {31'd0, irq}, 32'd0);
        run_to(13); check("data after commit", readdata, 32'h1);
                    check("irq after commit", {31'd0, irq}, ie(32'h1));
        address = 2'd2;
        run_to(14); check("edge after commit", readdata, ie(32'h1));
        write = 1'b1; writedata = 32'h1;
        run_to(15); write = 1'b0;
        run_to(16); check("edge after w1c", readdata, 32'h0);
                    check("irq after w1c", {31'd0, irq}, 32'h0);
        in_port = 10'h000;
        run_to(27); write = 1'b1; writedata = 32'h1;
        run_to(28); write = 1'b0;
        run_to(29); check("edge w1c vs commit", readdata, ie(32'h1));
                    check("irq w1c vs commit", {31'd0, irq}, ie(32'h1));
        address = 2'd0;
        run_to(30); check("data after fall commit", readdata, 32'h0);

        // Glitch on bit 5 lasting two ticks is rejected
        reset_dut();
        in_port = 10'h020; address = 2'd0;
        run_to(8); in_port = 10'h000;
        run_to(17); check("glitch data", readdata, 32'h0);
        address = 2'd2;
        run_to(18); check("glitch edge", readdata, 32'h0);
                    check("glitch irq", {31'd0, irq}, 32'h0);

        // Bypass: stable follows sync every cycle
        reset_dut();
        address = 2'd3; write = 1'b1; writedata = 32'h1;
        run_to(1);
        write = 1'b0; address = 2'd0; in_port = 10'h3FF;
        run_to(4); check("bypass data early", readdata, 32'h0);
        run_to(5); check("bypass data", readdata, 32'h3FF);
        address = 2'd2;
        run_to(6); check("bypass edge", readdata, ie(32'h3FF));

        // Reset while bit 2 is pending discards the count
        reset_dut();
        address = 2'd3; write = 1'b1; writedata = 32'h1;
        run_to(1);
        write = 1'b0; address = 2'd0; in_port = 10'h004;
        run_to(4);
        address = 2'd3; write = 1'b1; writedata = 32'h0;
        run_to(5);
        write = 1'b0; address = 2'd0; in_port = 10'h000;
        run_to(12); check("pre-reset data", readdata, 32'h4);
        in_port = 10'h004; address = 2'd2;
        reset_dut();
        run_to(1); check("post-reset edge", readdata, 32'h0);
                   check("post-reset irq", {31'd0, irq}, 32'h0);
        address = 2'd0;
        run_to(2); check("post-reset data", readdata, 32'h0);
        run_to(12); check("no early commit", readdata, 32'h0);
        run_to(13); check("fresh commit", readdata, 32'h4);
        address = 2'd2;
        run_to(14); check("fresh commit edge", readdata, ie(32'h4));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
